seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 75 +++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: 32-bit signed restoring divider, 33-edge latency from start to done.
// Results are registered copies, so the outputs keep their last values while a division is running.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             in_reset,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_div_by_zero
);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  state_t           state;
  logic [WIDTH:0]   rem, shifted, diff;
  logic [WIDTH-1:0] quo, dvs;
  logic [5:0]       cnt;
  logic             neg_q, neg_r, dz;
  always_comb begin
    shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
  end
  always_ff @(posedge clk or negedge in_reset) begin
    if (!in_reset) begin
      state           <= IDLE;
      rem             <= '0;
      quo             <= '0;
      dvs             <= '0;
      cnt             <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      dz              <= 1'b0;
      out_quotient    <= '0;
      out_remainder   <= '0;
      out_busy        <= 1'b0;
      out_done        <= 1'b0;
      out_div_by_zero <= 1'b0;
    end else if (in_start) begin
      state           <= ITER;
      rem             <= '0;
      quo             <= in_dividend[WIDTH-1] ? -in_dividend : in_dividend;
      dvs             <= in_divisor[WIDTH-1] ? -in_divisor : in_divisor;
      cnt             <= '0;
      neg_q           <= in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1];
      neg_r           <= in_dividend[WIDTH-1];
      dz              <= in_divisor == '0;
      out_busy        <= 1'b1;
      out_done        <= 1'b0;
      out_div_by_zero <= 1'b0;
    end else begin
      case (state)
        ITER: begin
          rem   <= diff[WIDTH] ? shifted : diff;
          quo   <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          cnt   <= cnt + 6'd1;
          state <= cnt == 6'(WIDTH - 1) ? FIX : ITER;
        end
        FIX: begin
          // a zero divisor yields all-ones quotient and |dividend| remainder, so only the quotient needs overriding
          out_quotient    <= dz ? '1 : neg_q ? -quo : quo;
          out_remainder   <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          out_div_by_zero <= dz;
          out_busy        <= 1'b0;
          out_done        <= 1'b1;
          state           <= DONE;
        end
        default: ;
      endcase
    end
  end
endmodule
